// File: rtl/l1c_mem_arbiter.sv
// Shares the CPU-wrapper memory port between the I-cache and D-cache refill engines.
// Optional round-robin tie-break on simultaneous requests: define ARB_RR_EN.
module l1c_mem_arbiter #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TYPE_W    = 3,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              I_req,
  input  logic [DATA_W-1:0] I_addr,
  input  logic              I_write,
  input  logic [DATA_W-1:0] I_in,
  input  logic [TYPE_W-1:0] I_type,
  output logic [DATA_W-1:0] I_out,
  output logic              I_wait,
  input  logic              D_req,
  input  logic [DATA_W-1:0] D_addr,
  input  logic              D_write,
  input  logic [DATA_W-1:0] D_in,
  input  logic [TYPE_W-1:0] D_type,
  output logic [DATA_W-1:0] D_out,
  output logic              D_wait,
  output logic              M_req,
  output logic [DATA_W-1:0] M_addr,
  output logic              M_write,
  output logic [DATA_W-1:0] M_in,
  output logic [TYPE_W-1:0] M_type,
  input  logic [DATA_W-1:0] M_out,
  input  logic              M_wait,
  output logic [1:0]        grant
);

  localparam int unsigned BEAT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [BEAT_W-1:0] beat, beat_nxt;
  logic              last_d, last_d_nxt;
  logic              prio_d;
  logic              pick_d;
  logic              beat_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      beat   <= '0;
      last_d <= 1'b1;
    end else begin
      state  <= state_nxt;
      beat   <= beat_nxt;
      last_d <= last_d_nxt;
    end
  end

  // Tie-break when both sides request in the same IDLE cycle
`ifdef ARB_RR_EN
  assign prio_d = !last_d;
`else
  assign prio_d = 1'b1;
`endif
  assign pick_d = D_req && (!I_req || prio_d);

  always_comb begin
    state_nxt  = state;
    beat_nxt   = beat;
    last_d_nxt = last_d;
    M_req      = 1'b0;
    M_addr     = '0;
    M_write    = 1'b0;
    M_in       = '0;
    M_type     = '0;
    I_out      = '0;
    I_wait     = 1'b1;
    D_out      = '0;
    D_wait     = 1'b1;
    grant      = 2'b00;
    beat_done  = 1'b0;

    case (state)
      IDLE: begin
        if (I_req || D_req) begin
          state_nxt  = pick_d ? GNT_D : GNT_I;
          last_d_nxt = pick_d;
        end
      end
      GNT_I: begin
        M_req   = I_req;
        M_addr  = I_addr;
        M_write = I_write;
        M_in    = I_in;
        M_type  = I_type;
        I_out   = M_out;
        I_wait  = M_wait;
        grant   = 2'b01;
      end
      GNT_D: begin
        M_req   = D_req;
        M_addr  = D_addr;
        M_write = D_write;
        M_in    = D_in;
        M_type  = D_type;
        D_out   = M_out;
        D_wait  = M_wait;
        grant   = 2'b10;
      end
      default: state_nxt = IDLE;
    endcase

    // Owner keeps the port until it drops req, finishes a write, or fills the line
    if (state == GNT_I || state == GNT_D) begin
      beat_done = M_req && !M_wait;
      if (!M_req || (beat_done && (M_write || beat == BEAT_W'(BURST_LEN - 1)))) begin
        state_nxt = IDLE;
        beat_nxt  = '0;
      end else if (beat_done) begin
        beat_nxt = beat + BEAT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_l1c_mem_arbiter.sv
// Directed and randomized bench for l1c_mem_arbiter against an ownership/beat-count model.
module tb_l1c_mem_arbiter;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned TYPE_W    = 3;
  localparam int unsigned BURST_LEN = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              I_req, I_write, I_wait;
  logic [DATA_W-1:0] I_addr, I_in, I_out;
  logic [TYPE_W-1:0] I_type;
  logic              D_req, D_write, D_wait;
  logic [DATA_W-1:0] D_addr, D_in, D_out;
  logic [TYPE_W-1:0] D_type;
  logic              M_req, M_write, M_wait;
  logic [DATA_W-1:0] M_addr, M_in, M_out;
  logic [TYPE_W-1:0] M_type;
  logic [1:0]        grant;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: who owns the port (0 none, 1 I, 2 D), beats done in this grant, last owner was D
  int m_own;
  int m_beat;
  bit m_last_d;

  l1c_mem_arbiter #(.DATA_W(DATA_W), .TYPE_W(TYPE_W), .BURST_LEN(BURST_LEN)) dut (
    .clk(clk), .rst(rst),
    .I_req(I_req), .I_addr(I_addr), .I_write(I_write), .I_in(I_in), .I_type(I_type),
    .I_out(I_out), .I_wait(I_wait),
    .D_req(D_req), .D_addr(D_addr), .D_write(D_write), .D_in(D_in), .D_type(D_type),
    .D_out(D_out), .D_wait(D_wait),
    .M_req(M_req), .M_addr(M_addr), .M_write(M_write), .M_in(M_in), .M_type(M_type),
    .M_out(M_out), .M_wait(M_wait),
    .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_own    = 0;
    m_beat   = 0;
    m_last_d = 1'b1;
  endtask

  // Expected port values follow directly from who owns the port right now
  task automatic check_all(input string ph);
    int own;
    own = rst ? 0 : m_own;
    check({ph, ".M_req"},   32'(M_req),   own == 1 ? 32'(I_req)   : own == 2 ? 32'(D_req)   : 32'd0);
    check({ph, ".M_addr"},  M_addr,       own == 1 ? I_addr       : own == 2 ? D_addr       : 32'd0);
    check({ph, ".M_write"}, 32'(M_write), own == 1 ? 32'(I_write) : own == 2 ? 32'(D_write) : 32'd0);
    check({ph, ".M_in"},    M_in,         own == 1 ? I_in         : own == 2 ? D_in         : 32'd0);
    check({ph, ".M_type"},  32'(M_type),  own == 1 ? 32'(I_type)  : own == 2 ? 32'(D_type)  : 32'd0);
    check({ph, ".I_out"},   I_out,        own == 1 ? M_out        : 32'd0);
    check({ph, ".I_wait"},  32'(I_wait),  own == 1 ? 32'(M_wait)  : 32'd1);
    check({ph, ".D_out"},   D_out,        own == 2 ? M_out        : 32'd0);
    check({ph, ".D_wait"},  32'(D_wait),  own == 2 ? 32'(M_wait)  : 32'd1);
    check({ph, ".grant"},   32'(grant),   32'(own));
    check({ph, ".beat"},    32'(dut.beat), rst ? 32'd0 : 32'(m_beat));
  endtask

  task automatic model_step();
    bit req, wr, done, take_d;
    if (rst) begin
      model_reset();
    end else if (m_own == 0) begin
      if (I_req || D_req) begin
`ifdef ARB_RR_EN
        take_d = D_req && (!I_req || !m_last_d);
`else
        take_d = D_req;
`endif
        m_own    = take_d ? 2 : 1;
        m_last_d = take_d;
      end
    end else begin
      req  = (m_own == 1) ? I_req : D_req;
      wr   = (m_own == 1) ? I_write : D_write;
      done = req && !M_wait;
      if (done) m_beat++;
      if (!req || (done && (wr || m_beat == BURST_LEN))) begin
        m_own  = 0;
        m_beat = 0;
      end
    end
  endtask

  // One clock: compare mid-cycle, advance the model across the edge
  task automatic cyc(input string ph);
    #2;
    check_all(ph);
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    I_req = 0; I_write = 0; I_addr = '0; I_in = '0; I_type = '0;
    D_req = 0; D_write = 0; D_addr = '0; D_in = '0; D_type = '0;
    M_wait = 1; M_out = '0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check_all("reset");
    rst = 1'b0;

    // Simultaneous requests: D write vs I refill
    I_req = 1; I_addr = 32'h0000_1000; I_type = 3'd2;
    D_req = 1; D_write = 1; D_addr = 32'h0000_2000; D_in = 32'hDEAD_BEEF; D_type = 3'd5;
    M_wait = 1;
    cyc("t2_idle");
    M_wait = 0; M_out = 32'h5555_0000;
`ifdef ARB_RR_EN
    #2; check("t2_first_grant", 32'(grant), 32'd1); check("t2_dwait", 32'(D_wait), 32'd1);
    cyc("t2_ib1"); repeat (3) cyc("t2_ib");
    I_req = 0;
    #2; check("t2_dead", 32'(grant), 32'd0);
    cyc("t2_dead_c");
    #2; check("t2_second_grant", 32'(grant), 32'd2);
    cyc("t2_dw");
    D_req = 0; D_write = 0;
    cyc("t2_end");
`else
    #2; check("t2_first_grant", 32'(grant), 32'd2); check("t2_iwait", 32'(I_wait), 32'd1);
    cyc("t2_dw");
    D_req = 0; D_write = 0;
    #2; check("t2_dead", 32'(grant), 32'd0);
    cyc("t2_dead_c");
    #2; check("t2_second_grant", 32'(grant), 32'd1); check("t2_iwait0", 32'(I_wait), 32'd0);
    cyc("t2_ib1"); repeat (3) cyc("t2_ib");
    I_req = 0;
    cyc("t2_end");
`endif

    // D read stalled five cycles
    D_req = 1; D_write = 0; D_addr = 32'h0000_3000; M_wait = 1; M_out = 32'h1234_5678;
    cyc("t3_idle");
    repeat (5) begin
      #2; check("t3_dwait_hi", 32'(D_wait), 32'd1); check("t3_grant", 32'(grant), 32'd2);
      cyc("t3_stall");
    end
    M_wait = 0; M_out = 32'h0000_CAFE;
    #2; check("t3_dout", D_out, 32'h0000_CAFE); check("t3_dwait_lo", 32'(D_wait), 32'd0);
    cyc("t3_done");
    M_wait = 1;
    #2; check("t3_beat", 32'(dut.beat), 32'd1); check("t3_hold", 32'(grant), 32'd2);
    cyc("t3_hold_c");
    D_req = 0;
    cyc("t3_rel"); cyc("t3_idle2");

    // Four-beat I refill
    I_req = 1; I_addr = 32'h0000_4000; M_wait = 0; M_out = 32'h0;
    #2; check("t1_mreq_c0", 32'(M_req), 32'd0);
    cyc("t1_idle");
    for (int k = 1; k <= 4; k++) begin
      M_out = 32'(k * 32'h11);
      #2; check("t1_iout", I_out, 32'(k * 32'h11)); check("t1_iwait", 32'(I_wait), 32'd0);
      check("t1_grant", 32'(grant), 32'd1);
      cyc("t1_beat");
    end
    I_req = 0;
    #2; check("t1_release", 32'(grant), 32'd0);
    cyc("t1_end");

    // Reset during the second beat of an I refill
    I_req = 1; M_wait = 0;
    cyc("t5_idle");
    M_out = 32'h1;
    cyc("t5_b1");
    M_out = 32'h2;
    #2; rst = 1'b1; #1;
    check("t5_rst_grant", 32'(grant), 32'd0); check("t5_rst_mreq", 32'(M_req), 32'd0);
    check("t5_rst_iwait", 32'(I_wait), 32'd1); check("t5_rst_iout", I_out, 32'd0);
    check("t5_rst_beat", 32'(dut.beat), 32'd0);
    @(posedge clk); model_reset(); #1;
    rst = 1'b0;
    #2; check("t5_post_idle", 32'(grant), 32'd0);
    cyc("t5_post");
    #2; check("t5_regrant", 32'(grant), 32'd1); check("t5_beat0", 32'(dut.beat), 32'd0);
    cyc("t5_b");
    I_req = 0;
    cyc("t5_rel"); cyc("t5_end");

    // I drops after two beats while D waits
    I_req = 1; M_wait = 0;
    cyc("t6_idle");
    D_req = 1; D_write = 0;
    cyc("t6_b1"); cyc("t6_b2");
    I_req = 0;
    #2; check("t6_still_i", 32'(grant), 32'd1); check("t6_dwait", 32'(D_wait), 32'd1);
    cyc("t6_rel");
    #2; check("t6_dead", 32'(grant), 32'd0);
    cyc("t6_dead_c");
    #2; check("t6_d_grant", 32'(grant), 32'd2);
    cyc("t6_d");
    D_req = 0;
    cyc("t6_drel"); cyc("t6_end");

    // Random traffic, with occasional resets
    repeat (800) begin
      rst     = ($urandom_range(0, 59) == 0);
      I_req   = ($urandom_range(0, 3) != 0);
      D_req   = ($urandom_range(0, 2) != 0);
      I_write = ($urandom_range(0, 15) == 0);
      D_write = ($urandom_range(0, 3) == 0);
      I_addr  = $urandom; I_in = $urandom; I_type = 3'($urandom);
      D_addr  = $urandom; D_in = $urandom; D_type = 3'($urandom);
      M_wait  = ($urandom_range(0, 2) == 0);
      M_out   = $urandom;
      cyc("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
